// File: rtl/hex_display_scanner_if.sv
// Display-scanner bus: value load/blanking controls in, digit/anode drive and status out.
// master = value source and display pins, slave = the scanner itself.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              digit_out;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    frame_start;
    logic                    pending;

    modport master (
        output value_in,
        output load,
        output blank_mask,
        input  digit_out,
        input  anode_n,
        input  frame_start,
        input  pending
    );

    modport slave (
        input  value_in,
        input  load,
        input  blank_mask,
        output digit_out,
        output anode_n,
        output frame_start,
        output pending
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display feeder: scans one nibble per slot onto digit_out with a
// blanking gap before each digit, committing newly loaded values only at frame boundaries.
module hex_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    hex_display_scanner_if.slave    bus
);
    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        S_GAP,
        S_ON
    } state_t;

    state_t                         state_q,   state_d;
    logic [CW-1:0]                  cnt_q,     cnt_d;
    logic [IW-1:0]                  idx_q,     idx_d;
    logic                           restart_q;
    logic [NUM_DIGITS-1:0][3:0]     disp_q,    disp_d;
    logic [NUM_DIGITS-1:0][3:0]     pend_q,    pend_d;
    logic                           pending_q, pending_d;
    logic [3:0]                     digit_q,   digit_d;
    logic [NUM_DIGITS-1:0]          anode_q,   anode_d;
    logic                           fs_q,      fs_d;
    logic                           enter_gap;
    logic                           frame_edge;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        digit_d   = digit_q;
        anode_d   = '1;
        fs_d      = 1'b0;
        enter_gap = 1'b0;

        // The first edge after reset release is treated as a wrap into digit 0's gap.
        if (restart_q) begin
            state_d   = S_GAP;
            cnt_d     = '0;
            idx_d     = '0;
            enter_gap = 1'b1;
        end else begin
            case (state_q)
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d   = S_GAP;
                        cnt_d     = '0;
                        enter_gap = 1'b1;
                        idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            endcase
        end

        frame_edge = enter_gap && (idx_d == '0);

        // A load on the commit edge bypasses the pending register entirely.
        if (frame_edge) begin
            if (bus.load) begin
                disp_d    = bus.value_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                disp_d    = pend_q;
                pending_d = 1'b0;
            end
        end else if (bus.load) begin
            pend_d    = bus.value_in;
            pending_d = 1'b1;
        end

        fs_d = frame_edge;

        if (enter_gap) begin
            digit_d = disp_d[idx_d];
        end

        if ((state_d == S_ON) && !bus.blank_mask[idx_d]) begin
            anode_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_GAP;
            cnt_q     <= '0;
            idx_q     <= '0;
            restart_q <= 1'b1;
            disp_q    <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            digit_q   <= '0;
            anode_q   <= '1;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            restart_q <= 1'b0;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            digit_q   <= digit_d;
            anode_q   <= anode_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.digit_out   = digit_q;
    assign bus.anode_n     = anode_q;
    assign bus.frame_start = fs_q;
    assign bus.pending     = pending_q;
endmodule
